// File: rtl/emulador_de_teclado.sv
// Single-key 4x4 keypad emulator. It presents one key to a row-scanning
// keypad decoder: press chatter, a stable closed phase, release chatter and
// a quiet gap. The chatter is driven by an 8-bit LFSR.
`timescale 1ns/1ps
module emulador_de_teclado #(
  parameter int BOUNCE_CYCLES = 16,
  parameter int GAP_CYCLES    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_tecla,
  input  logic [15:0] cmd_hold,
  input  logic [3:0]  lin_matriz,
  output logic [3:0]  col_matriz,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_BOUNCE,
    HOLD,
    RELEASE_BOUNCE,
    GAP
  } state_t;

  // Last index of each timed phase; clamped so a zero-length phase stays in range.
  localparam logic [15:0] BOUNCE_LAST = 16'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [15:0] GAP_LAST    = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [7:0]  LFSR_SEED   = 8'hA5;

  state_t      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [3:0]  row_q, row_d;
  logic [3:0]  col_q, col_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] hold_q, hold_d;
  logic        done_q, done_d;

  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic [7:0]  lfsr_next;
  logic        contact;

  // Keypad layout: key value to its active-low (row, col) pair.
  always_comb begin
    key_row = 4'b1111;
    key_col = 4'b1111;
    case (cmd_tecla)
      4'h1: begin key_row = 4'b0111; key_col = 4'b0111; end
      4'h2: begin key_row = 4'b0111; key_col = 4'b1011; end
      4'h3: begin key_row = 4'b0111; key_col = 4'b1101; end
      4'hA: begin key_row = 4'b0111; key_col = 4'b1110; end
      4'h4: begin key_row = 4'b1011; key_col = 4'b0111; end
      4'h5: begin key_row = 4'b1011; key_col = 4'b1011; end
      4'h6: begin key_row = 4'b1011; key_col = 4'b1101; end
      4'hB: begin key_row = 4'b1011; key_col = 4'b1110; end
      4'h7: begin key_row = 4'b1101; key_col = 4'b0111; end
      4'h8: begin key_row = 4'b1101; key_col = 4'b1011; end
      4'h9: begin key_row = 4'b1101; key_col = 4'b1101; end
      4'hC: begin key_row = 4'b1101; key_col = 4'b1110; end
      4'hF: begin key_row = 4'b1110; key_col = 4'b0111; end
      4'h0: begin key_row = 4'b1110; key_col = 4'b1011; end
      4'hE: begin key_row = 4'b1110; key_col = 4'b1101; end
      default: begin key_row = 4'b1110; key_col = 4'b1110; end
    endcase
  end

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Sequencer: phase timing, command capture and contact state.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    contact = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          row_d  = key_row;
          col_d  = key_col;
          hold_d = (cmd_hold == 16'd0) ? 16'd1 : cmd_hold;
          cnt_d  = 16'd0;
          state_d = (BOUNCE_CYCLES == 0) ? HOLD : PRESS_BOUNCE;
        end
      end
      PRESS_BOUNCE: begin
        contact = lfsr_q[0];
        lfsr_d  = lfsr_next;
        if (cnt_q == BOUNCE_LAST) begin
          cnt_d   = 16'd0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      HOLD: begin
        contact = 1'b1;
        if (hold_q == 16'd1) begin
          cnt_d = 16'd0;
          if (BOUNCE_CYCLES != 0) begin
            state_d = RELEASE_BOUNCE;
          end else if (GAP_CYCLES != 0) begin
            state_d = GAP;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end
      RELEASE_BOUNCE: begin
        contact = lfsr_q[0];
        lfsr_d  = lfsr_next;
        if (cnt_q == BOUNCE_LAST) begin
          cnt_d = 16'd0;
          if (GAP_CYCLES != 0) begin
            state_d = GAP;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = 16'd0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset wins over any same-cycle handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      row_q   <= 4'b1111;
      col_q   <= 4'b1111;
      cnt_q   <= 16'd0;
      hold_q  <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

  // Column sense follows the scanner's rows combinationally; any low row
  // matching the key's row closes the path.
  assign col_matriz = (contact && ((~lin_matriz & ~row_q) != 4'b0000)) ? col_q : 4'b1111;
  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_emulador_de_teclado.sv
// Bench for emulador_de_teclado: two instances (default timing and no
// bounce/no gap) share stimulus and are checked every cycle against a
// per-instance expected-cycle queue built at each accepted command.
`timescale 1ns/1ps
module tb_emulador_de_teclado;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [3:0]  cmd_tecla = 4'h0;
  logic [15:0] cmd_hold = 16'd0;
  logic [3:0]  lin_matriz = 4'b1111;

  logic [3:0]  col_w   [2];
  logic        ready_w [2];
  logic        busy_w  [2];
  logic        done_w  [2];

  always #5 clk = ~clk;

  emulador_de_teclado #(.BOUNCE_CYCLES(16), .GAP_CYCLES(8)) dut_a (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_w[0]),
    .cmd_tecla(cmd_tecla), .cmd_hold(cmd_hold), .lin_matriz(lin_matriz),
    .col_matriz(col_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  emulador_de_teclado #(.BOUNCE_CYCLES(0), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_w[1]),
    .cmd_tecla(cmd_tecla), .cmd_hold(cmd_hold), .lin_matriz(lin_matriz),
    .col_matriz(col_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  // One expected cycle of the key sequence.
  typedef struct packed {
    logic       contact;
    logic       busy;
    logic       done;
    logic [3:0] key;
  } rec_t;

  rec_t       mbuf [2][0:1023];
  int         mhead [2];
  int         mcnt  [2];
  rec_t       mcur  [2];
  logic [7:0] mlfsr [2];
  bit         model_ok = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [3:0] obs_col   [2];
  logic       obs_busy  [2];
  logic       obs_ready [2];
  logic       obs_done  [2];

  function automatic int bounce_of(input int k);
    return (k == 0) ? 16 : 0;
  endfunction

  function automatic int gap_of(input int k);
    return (k == 0) ? 8 : 0;
  endfunction

  // Keypad layout as a lookup: {row, col}, both active-low.
  function automatic logic [7:0] key_map(input logic [3:0] key);
    logic [7:0] tbl [16];
    tbl[4'h1] = 8'h77; tbl[4'h2] = 8'h7B; tbl[4'h3] = 8'h7D; tbl[4'hA] = 8'h7E;
    tbl[4'h4] = 8'hB7; tbl[4'h5] = 8'hBB; tbl[4'h6] = 8'hBD; tbl[4'hB] = 8'hBE;
    tbl[4'h7] = 8'hD7; tbl[4'h8] = 8'hDB; tbl[4'h9] = 8'hDD; tbl[4'hC] = 8'hDE;
    tbl[4'hF] = 8'hE7; tbl[4'h0] = 8'hEB; tbl[4'hE] = 8'hED; tbl[4'hD] = 8'hEE;
    return tbl[key];
  endfunction

  // Next LFSR value: feedback is the parity of taps 8,6,5,4 (bits 7,5,4,3).
  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    return {x[6:0], ^(x & 8'hB8)};
  endfunction

  task automatic push_rec(input int k, input rec_t r);
    mbuf[k][(mhead[k] + mcnt[k]) % 1024] = r;
    mcnt[k]++;
  endtask

  // Expand one accepted command into its full expected cycle list.
  task automatic push_seq(input int k, input logic [3:0] t, input logic [15:0] h);
    int hh;
    hh = (h == 16'd0) ? 1 : int'(h);
    $display("TXN dut%0d key=%h hold=%0d at %0t", k, t, h, $time);
    for (int i = 0; i < bounce_of(k); i++) begin
      push_rec(k, '{contact: mlfsr[k][0], busy: 1'b1, done: 1'b0, key: t});
      mlfsr[k] = lfsr_step(mlfsr[k]);
    end
    for (int i = 0; i < hh; i++) push_rec(k, '{contact: 1'b1, busy: 1'b1, done: 1'b0, key: t});
    for (int i = 0; i < bounce_of(k); i++) begin
      push_rec(k, '{contact: mlfsr[k][0], busy: 1'b1, done: 1'b0, key: t});
      mlfsr[k] = lfsr_step(mlfsr[k]);
    end
    for (int i = 0; i < gap_of(k); i++) push_rec(k, '{contact: 1'b0, busy: 1'b1, done: 1'b0, key: t});
    push_rec(k, '{contact: 1'b0, busy: 1'b0, done: 1'b1, key: t});
  endtask

  // Advance the model across one clock edge using the inputs the DUT sampled.
  task automatic model_step(input logic r, input logic v, input logic [3:0] t, input logic [15:0] h);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        mcnt[k]  = 0;
        mhead[k] = 0;
        mlfsr[k] = 8'hA5;
        mcur[k]  = '0;
      end else begin
        if (v && !mcur[k].busy) push_seq(k, t, h);
        if (mcnt[k] > 0) begin
          mcur[k]  = mbuf[k][mhead[k]];
          mhead[k] = (mhead[k] + 1) % 1024;
          mcnt[k]--;
        end else begin
          mcur[k] = '0;
        end
      end
    end
    if (r) model_ok = 1'b1;
  endtask

  task automatic chk(input string nm, input int k, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%h expected=%h t=%0t", nm, k, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [7:0] rc;
    logic [3:0] exp_col;
    for (int k = 0; k < 2; k++) begin
      rc = key_map(mcur[k].key);
      exp_col = (mcur[k].contact && ((~lin_matriz & ~rc[7:4]) != 4'b0000)) ? rc[3:0] : 4'b1111;
      chk("col_matriz", k, {12'd0, col_w[k]}, {12'd0, exp_col});
      chk("busy", k, {15'd0, busy_w[k]}, {15'd0, mcur[k].busy});
      chk("cmd_ready", k, {15'd0, ready_w[k]}, {15'd0, !mcur[k].busy});
      chk("done", k, {15'd0, done_w[k]}, {15'd0, mcur[k].done});
      obs_col[k]   = col_w[k];
      obs_busy[k]  = busy_w[k];
      obs_ready[k] = ready_w[k];
      obs_done[k]  = done_w[k];
    end
  endtask

  // Drive one cycle of inputs, check mid-cycle, then cross the clock edge.
  task automatic cycle(input logic r, input logic v, input logic [3:0] t, input logic [15:0] h,
                       input logic [3:0] l);
    rst = r; cmd_valid = v; cmd_tecla = t; cmd_hold = h; lin_matriz = l;
    #1;
    if (model_ok) compare_all();
    @(posedge clk);
    model_step(r, v, t, h);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 4'h0, 16'd0, 4'b1111);
    cycle(1'b1, 1'b1, 4'h3, 16'd5, 4'b1111);
  endtask

  task automatic idle_cycles(input int n, input logic [3:0] l);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'h0, 16'd0, l);
  endtask

  initial begin
    int cnt_a;
    int cnt_b;
    int done_at;

    @(negedge clk);
    do_reset();
    // Reset state, checked as literals.
    cycle(1'b0, 1'b0, 4'h0, 16'd0, 4'b0000);
    chk("reset_col", 0, {12'd0, obs_col[0]}, 16'h000F);
    chk("reset_ready", 0, {15'd0, obs_ready[0]}, 16'd1);
    chk("reset_busy", 1, {15'd0, obs_busy[1]}, 16'd0);

    // No-bounce instance: key 6, hold 10, row 1 driven.
    do_reset();
    cycle(1'b0, 1'b1, 4'h6, 16'd10, 4'b1011);
    cnt_b = 0; done_at = -1;
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b0, 1'b0, 4'h0, 16'd0, 4'b1011);
      if (obs_col[1] == 4'b1101) cnt_b++;
      if (i == 1) chk("k6_first_closed", 1, {12'd0, obs_col[1]}, 16'h000D);
      if (obs_done[1] && done_at < 0) done_at = i;
    end
    chk("k6_closed_cycles", 1, 16'(cnt_b), 16'd10);
    chk("k6_done_cycle", 1, 16'(done_at), 16'd11);
    idle_cycles(50, 4'b1011);
    // Wrong row driven: contact never seen.
    cycle(1'b0, 1'b1, 4'h6, 16'd10, 4'b0111);
    cnt_b = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b0, 1'b0, 4'h0, 16'd0, 4'b0111);
      if (obs_col[1] != 4'b1111) cnt_b++;
    end
    chk("k6_wrong_row", 1, 16'(cnt_b), 16'd0);
    idle_cycles(50, 4'b0111);

    // Default instance: key 0, hold 300, row 3 driven.
    do_reset();
    cycle(1'b0, 1'b1, 4'h0, 16'd300, 4'b1110);
    cnt_a = 0; cnt_b = 0; done_at = -1;
    for (int i = 1; i <= 345; i++) begin
      cycle(1'b0, 1'b0, 4'h0, 16'd0, 4'b1110);
      if (i == 1) chk("lfsr_c1", 0, {12'd0, obs_col[0]}, 16'h000B);
      if (i == 2) chk("lfsr_c2", 0, {12'd0, obs_col[0]}, 16'h000F);
      if (i == 3) chk("lfsr_c3", 0, {12'd0, obs_col[0]}, 16'h000B);
      if (i >= 17 && i <= 316 && obs_col[0] == 4'b1011) cnt_a++;
      if (i >= 333 && i <= 340 && obs_col[0] == 4'b1111) cnt_b++;
      if (obs_done[0] && done_at < 0) done_at = i;
    end
    chk("k0_stable_cycles", 0, 16'(cnt_a), 16'd300);
    chk("k0_gap_open", 0, 16'(cnt_b), 16'd8);
    chk("k0_done_cycle", 0, 16'(done_at), 16'd341);

    // cmd_valid held during busy with changing keys.
    do_reset();
    for (int i = 0; i <= 60; i++) begin
      cycle(1'b0, 1'b1, (i == 0) ? 4'h5 : ((i == 4) ? 4'h9 : 4'((i * 7) % 16)), 16'd3, 4'b0000);
      if (i == 2) chk("first_key_kept", 1, {12'd0, obs_col[1]}, 16'h000B);
      if (i == 4) chk("done_with_ready", 1, {14'd0, obs_done[1], obs_ready[1]}, 16'd3);
      if (i == 5) chk("second_key", 1, {12'd0, obs_col[1]}, 16'h000D);
    end
    idle_cycles(60, 4'b0000);

    // Reset in the middle of HOLD, key A.
    do_reset();
    cycle(1'b0, 1'b1, 4'hA, 16'd50, 4'b0111);
    for (int i = 1; i <= 25; i++) cycle(1'b0, 1'b0, 4'h0, 16'd0, 4'b0111);
    chk("kA_closed", 0, {12'd0, obs_col[0]}, 16'h000E);
    cycle(1'b1, 1'b0, 4'h0, 16'd0, 4'b0111);
    cnt_a = 0;
    for (int i = 0; i < 70; i++) begin
      cycle(1'b0, 1'b0, 4'h0, 16'd0, 4'b0111);
      if (i == 0) begin
        chk("rst_col", 0, {12'd0, obs_col[0]}, 16'h000F);
        chk("rst_busy_ready", 0, {14'd0, obs_busy[0], obs_ready[0]}, 16'd1);
      end
      if (obs_done[0]) cnt_a++;
    end
    chk("rst_no_done", 0, 16'(cnt_a), 16'd0);

    // Zero hold with all rows low, key D.
    do_reset();
    cycle(1'b0, 1'b1, 4'hD, 16'd0, 4'b0000);
    cycle(1'b0, 1'b0, 4'h0, 16'd0, 4'b0000);
    chk("h0_closed", 1, {12'd0, obs_col[1]}, 16'h000E);
    cycle(1'b0, 1'b0, 4'h0, 16'd0, 4'b0000);
    chk("h0_open_done", 1, {11'd0, obs_col[1], obs_done[1]}, 16'h001F);
    idle_cycles(60, 4'b0000);

    // Randomized traffic: keys, holds, row patterns, valid and rare resets.
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0),
            4'($urandom_range(0, 15)), 16'($urandom_range(0, 40)), 4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
